// File: rtl/swap_endianness_stream.sv
// Registered byte swapper with per-beat lane size (none/16/32/full) and a 2-entry skid buffer.
// 1-cycle latency; in_ready is registered and drops only while the skid register holds a beat.
module swap_endianness_stream #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_vect,
   input  logic [WIDTH/8-1:0] in_keep,
   input  logic               in_last,
   input  logic [1:0]         in_mode,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_vect,
   output logic [WIDTH/8-1:0] out_keep,
   output logic               out_last,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int NB = WIDTH / 8;
   localparam int IW = $clog2(NB);

   // Lane sizes are powers of two, so the byte permutation is an XOR of the
   // byte index with (L-1); lanes wider than the bus clamp to the full width.
   localparam logic [IW-1:0] MASK_16   = IW'(1);
   localparam logic [IW-1:0] MASK_32   = IW'((NB >= 4) ? 3 : NB - 1);
   localparam logic [IW-1:0] MASK_FULL = IW'(NB - 1);

   typedef struct packed {
      logic [WIDTH-1:0] vect;
      logic [NB-1:0]    keep;
      logic             last;
   } beat_t;

   beat_t         swapped;
   beat_t         out_q;
   beat_t         skid_q;
   logic          out_valid_q;
   logic          skid_valid_q;
   logic          skid_valid_d;
   logic          in_ready_q;
   logic          accept;
   logic          drain;
   logic [IW-1:0] mask;
   logic [IW-1:0] src;

   always_comb begin
      mask = '0;
      unique case (in_mode)
         2'd0: mask = '0;
         2'd1: mask = MASK_16;
         2'd2: mask = MASK_32;
         2'd3: mask = MASK_FULL;
      endcase
   end

   always_comb begin
      swapped      = '0;
      src          = '0;
      swapped.last = in_last;
      for (int i = 0; i < NB; i++) begin
         src                     = IW'(i) ^ mask;
         swapped.vect[8*i +: 8]  = in_vect[8*src +: 8];
         swapped.keep[i]         = in_keep[src];
      end
   end

   assign accept = in_valid & in_ready_q;
   assign drain  = out_valid_q & out_ready;

   // The skid only fills when the output is held; it always empties on a drain
   // because in_ready was low while it was occupied.
   always_comb begin
      if (drain || !out_valid_q) begin
         skid_valid_d = 1'b0;
      end else begin
         skid_valid_d = skid_valid_q | accept;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= ~skid_valid_d;
         if (drain || !out_valid_q) begin
            if (skid_valid_q) begin
               out_q       <= skid_q;
               out_valid_q <= 1'b1;
            end else if (accept) begin
               out_q       <= swapped;
               out_valid_q <= 1'b1;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (accept) begin
            skid_q <= swapped;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_vect  = out_q.vect;
   assign out_keep  = out_q.keep;
   assign out_last  = out_q.last;

endmodule

// File: tb/tb_swap_endianness_stream.sv
// Directed bench for swap_endianness_stream at WIDTH 64, 16 and 256, plus a scoreboarded random stream.
module tb_swap_endianness_stream;

   logic clk;
   logic rst;

   logic [63:0]  a_in_vect;
   logic [7:0]   a_in_keep;
   logic         a_in_last;
   logic [1:0]   a_in_mode;
   logic         a_in_valid;
   logic         a_in_ready;
   logic [63:0]  a_out_vect;
   logic [7:0]   a_out_keep;
   logic         a_out_last;
   logic         a_out_valid;
   logic         a_out_ready;

   logic [15:0]  b_in_vect;
   logic [1:0]   b_in_keep;
   logic         b_in_last;
   logic [1:0]   b_in_mode;
   logic         b_in_valid;
   logic         b_in_ready;
   logic [15:0]  b_out_vect;
   logic [1:0]   b_out_keep;
   logic         b_out_last;
   logic         b_out_valid;
   logic         b_out_ready;

   logic [255:0] c_in_vect;
   logic [31:0]  c_in_keep;
   logic         c_in_last;
   logic [1:0]   c_in_mode;
   logic         c_in_valid;
   logic         c_in_ready;
   logic [255:0] c_out_vect;
   logic [31:0]  c_out_keep;
   logic         c_out_last;
   logic         c_out_valid;
   logic         c_out_ready;

   int total = 0;
   int bad   = 0;

   swap_endianness_stream #(.WIDTH(64)) u_a (
      .clk(clk), .rst(rst),
      .in_vect(a_in_vect), .in_keep(a_in_keep), .in_last(a_in_last), .in_mode(a_in_mode),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_vect(a_out_vect), .out_keep(a_out_keep), .out_last(a_out_last),
      .out_valid(a_out_valid), .out_ready(a_out_ready)
   );

   swap_endianness_stream #(.WIDTH(16)) u_b (
      .clk(clk), .rst(rst),
      .in_vect(b_in_vect), .in_keep(b_in_keep), .in_last(b_in_last), .in_mode(b_in_mode),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_vect(b_out_vect), .out_keep(b_out_keep), .out_last(b_out_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   swap_endianness_stream #(.WIDTH(256)) u_c (
      .clk(clk), .rst(rst),
      .in_vect(c_in_vect), .in_keep(c_in_keep), .in_last(c_in_last), .in_mode(c_in_mode),
      .in_valid(c_in_valid), .in_ready(c_in_ready),
      .out_vect(c_out_vect), .out_keep(c_out_keep), .out_last(c_out_last),
      .out_valid(c_out_valid), .out_ready(c_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference permutation written straight from the byte mapping formula.
   function automatic logic [255:0] perm_vect(input logic [255:0] d, input int nb, input logic [1:0] mode);
      int l;
      int src;
      logic [255:0] r;
      r = '0;
      case (mode)
         2'd0:    l = 1;
         2'd1:    l = 2;
         2'd2:    l = 4;
         default: l = nb;
      endcase
      if (l > nb) l = nb;
      for (int i = 0; i < nb; i++) begin
         src = i - (i % l) + (l - 1 - (i % l));
         r[8*i +: 8] = d[8*src +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] perm_keep(input logic [31:0] k, input int nb, input logic [1:0] mode);
      int l;
      int src;
      logic [31:0] r;
      r = '0;
      case (mode)
         2'd0:    l = 1;
         2'd1:    l = 2;
         2'd2:    l = 4;
         default: l = nb;
      endcase
      if (l > nb) l = nb;
      for (int i = 0; i < nb; i++) begin
         src = i - (i % l) + (l - 1 - (i % l));
         r[i] = k[src];
      end
      return r;
   endfunction

   localparam int NR = 1000;

   logic [63:0]  qv[$];
   logic [7:0]   qk[$];
   logic         ql[$];
   logic [255:0] tmp_v;
   logic [31:0]  tmp_k;
   logic [255:0] exp256;
   logic [73:0]  snap;
   logic         stalled;
   logic         acc;
   int           sent;
   int           got;
   int           cyc;

   initial begin
      rst = 1'b1;
      a_in_vect = '0; a_in_keep = '0; a_in_last = 1'b0; a_in_mode = 2'd0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      b_in_vect = '0; b_in_keep = '0; b_in_last = 1'b0; b_in_mode = 2'd0; b_in_valid = 1'b0; b_out_ready = 1'b0;
      c_in_vect = '0; c_in_keep = '0; c_in_last = 1'b0; c_in_mode = 2'd0; c_in_valid = 1'b0; c_out_ready = 1'b0;

      // Reset state
      step();
      chk("rst_out_valid", 256'(a_out_valid), 256'(1'b0));
      chk("rst_in_ready",  256'(a_in_ready),  256'(1'b1));
      chk("rst_out_vect",  256'(a_out_vect),  256'(0));
      chk("rst_out_keep",  256'(a_out_keep),  256'(0));
      chk("rst_out_last",  256'(a_out_last),  256'(1'b0));
      step();
      rst = 1'b0;

      // Four modes on consecutive cycles
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_vect   = 64'h0001020304050607;
      a_in_keep   = 8'hFF;
      a_in_mode   = 2'd3;
      step();
      chk("m3_vect",  256'(a_out_vect),  256'(64'h0706050403020100));
      chk("m3_valid", 256'(a_out_valid), 256'(1'b1));
      chk("m3_ready", 256'(a_in_ready),  256'(1'b1));
      a_in_mode = 2'd2;
      step();
      chk("m2_vect",  256'(a_out_vect),  256'(64'h0302010007060504));
      chk("m2_ready", 256'(a_in_ready),  256'(1'b1));
      a_in_mode = 2'd1;
      step();
      chk("m1_vect",  256'(a_out_vect),  256'(64'h0100030205040706));
      chk("m1_ready", 256'(a_in_ready),  256'(1'b1));
      a_in_mode = 2'd0;
      step();
      chk("m0_vect",  256'(a_out_vect),  256'(64'h0001020304050607));
      chk("m0_ready", 256'(a_in_ready),  256'(1'b1));

      // Keep mapping and last pass-through
      a_in_mode = 2'd3; a_in_keep = 8'h0F; a_in_last = 1'b1;
      step();
      chk("keep_m3", 256'(a_out_keep), 256'(8'hF0));
      chk("last_m3", 256'(a_out_last), 256'(1'b1));
      a_in_mode = 2'd1; a_in_keep = 8'b00000001; a_in_last = 1'b0;
      step();
      chk("keep_m1", 256'(a_out_keep), 256'(8'b00000010));
      chk("last_m1", 256'(a_out_last), 256'(1'b0));
      a_in_valid = 1'b0;
      step();
      chk("idle_valid", 256'(a_out_valid), 256'(1'b0));

      // Backpressure: output holds beat 1, skid takes beat 2
      a_out_ready = 1'b0; a_in_mode = 2'd0; a_in_keep = 8'hFF;
      a_in_valid = 1'b1; a_in_vect = 64'd1;
      step();
      chk("bp_b1_vect",  256'(a_out_vect), 256'(64'd1));
      chk("bp_b1_ready", 256'(a_in_ready), 256'(1'b1));
      a_in_vect = 64'd2;
      step();
      chk("bp_b2_hold",  256'(a_out_vect), 256'(64'd1));
      chk("bp_b2_ready", 256'(a_in_ready), 256'(1'b0));
      a_in_vect = 64'd3;
      step();
      chk("bp_stall_vect",  256'(a_out_vect),  256'(64'd1));
      chk("bp_stall_valid", 256'(a_out_valid), 256'(1'b1));
      chk("bp_stall_ready", 256'(a_in_ready),  256'(1'b0));
      a_out_ready = 1'b1;
      step();
      chk("bp_out2",       256'(a_out_vect), 256'(64'd2));
      chk("bp_ready_back", 256'(a_in_ready), 256'(1'b1));
      step();
      chk("bp_out3", 256'(a_out_vect), 256'(64'd3));
      a_in_vect = 64'd4;
      step();
      chk("bp_out4", 256'(a_out_vect), 256'(64'd4));
      a_in_valid = 1'b0;
      step();
      chk("bp_drained", 256'(a_out_valid), 256'(1'b0));

      // Narrow and wide instances
      b_in_vect = 16'h1234; b_in_keep = 2'b01; b_in_mode = 2'd2; b_in_valid = 1'b1; b_out_ready = 1'b1;
      for (int i = 0; i < 32; i++) c_in_vect[8*i +: 8] = 8'(i);
      c_in_keep = 32'h0000FFFF; c_in_mode = 2'd3; c_in_valid = 1'b1; c_out_ready = 1'b1;
      step();
      for (int i = 0; i < 32; i++) exp256[8*i +: 8] = 8'(31 - i);
      chk("w16_vect", 256'(b_out_vect), 256'(16'h3412));
      chk("w16_keep", 256'(b_out_keep), 256'(2'b10));
      chk("w256_vect", c_out_vect, exp256);
      chk("w256_keep", 256'(c_out_keep), 256'(32'hFFFF0000));
      b_in_valid = 1'b0; c_in_valid = 1'b0;

      // Random valid/ready with scoreboard
      sent = 0; got = 0; cyc = 0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      while (got < NR && cyc < 20000) begin
         cyc++;
         stalled = a_out_valid && !a_out_ready;
         snap    = {a_out_valid, a_out_vect, a_out_keep, a_out_last};
         if (a_out_valid && a_out_ready) begin
            chk("rnd_q_nonempty", 256'(qv.size() != 0), 256'(1'b1));
            if (qv.size() != 0) begin
               chk("rnd_vect", 256'(a_out_vect), 256'(qv.pop_front()));
               chk("rnd_keep", 256'(a_out_keep), 256'(qk.pop_front()));
               chk("rnd_last", 256'(a_out_last), 256'(ql.pop_front()));
               got++;
            end
         end
         acc = a_in_valid && a_in_ready;
         if (acc) begin
            tmp_v = perm_vect(256'(a_in_vect), 8, a_in_mode);
            tmp_k = perm_keep(32'(a_in_keep), 8, a_in_mode);
            qv.push_back(tmp_v[63:0]);
            qk.push_back(tmp_k[7:0]);
            ql.push_back(a_in_last);
            sent++;
         end
         step();
         if (stalled) chk("rnd_stable", 256'({a_out_valid, a_out_vect, a_out_keep, a_out_last}), 256'(snap));
         if (acc || !a_in_valid) begin
            a_in_vect  = {$urandom, $urandom};
            a_in_keep  = 8'($urandom_range(0, 255));
            a_in_last  = 1'($urandom_range(0, 1));
            a_in_mode  = 2'($urandom_range(0, 3));
            a_in_valid = (sent < NR) && ($urandom_range(0, 3) != 0);
         end
         a_out_ready = ($urandom_range(0, 3) != 0);
      end
      chk("rnd_count", 256'(got), 256'(NR));
      chk("rnd_left",  256'(qv.size()), 256'(0));

      // Reset with both registers full
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      step(); step(); step();
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 2'd0; a_in_keep = 8'hFF; a_in_last = 1'b1;
      a_in_vect = 64'h11;
      step();
      a_in_vect = 64'h22;
      step();
      chk("full_ready", 256'(a_in_ready),  256'(1'b0));
      chk("full_valid", 256'(a_out_valid), 256'(1'b1));
      rst = 1'b1; a_out_ready = 1'b1;
      step();
      chk("mrst_out_valid", 256'(a_out_valid), 256'(1'b0));
      chk("mrst_in_ready",  256'(a_in_ready),  256'(1'b1));
      chk("mrst_out_vect",  256'(a_out_vect),  256'(0));
      chk("mrst_out_keep",  256'(a_out_keep),  256'(0));
      chk("mrst_out_last",  256'(a_out_last),  256'(1'b0));
      rst = 1'b0;
      a_in_vect = 64'haabbccdd00112233; a_in_mode = 2'd2; a_in_last = 1'b0;
      step();
      chk("post_rst_vect",  256'(a_out_vect),  256'(64'hddccbbaa33221100));
      chk("post_rst_valid", 256'(a_out_valid), 256'(1'b1));
      a_in_valid = 1'b0;
      step();
      chk("post_rst_idle", 256'(a_out_valid), 256'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
